// File: rtl/rw_reg_bank_pkg.sv
// rw_reg_bank_pkg: shared types and mode-bit positions for the register bank
package rw_reg_bank_pkg;
  typedef enum logic [1:0] {ACC_RW, ACC_RO, ACC_W1C, ACC_RC} acc_type_e;
  typedef enum logic [1:0] {ST_LOCKED, ST_KEY0_OK, ST_UNLOCKED} unlock_st_e;
  localparam int M_TEST  = 0;
  localparam int M_CFG   = 1;
  localparam int M_SPI   = 2;
  localparam int M_EFUSE = 3;
endpackage

// File: rtl/rw_reg_unlock_fsm.sv
// rw_reg_unlock_fsm: two-key unlock sequencer with per-state timeout
module rw_reg_unlock_fsm
  import rw_reg_bank_pkg::*;
#(
  parameter int DW = 8,
  parameter logic [DW-1:0] KEY0 = 8'hA5,
  parameter logic [DW-1:0] KEY1 = 8'h5A,
  parameter int UNLOCK_WIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr,
  input  logic [DW-1:0] key_data,
  input  logic          prot_wr_done,
  output logic          unlocked
);
  localparam int CW = $clog2(UNLOCK_WIN + 1);
  unlock_st_e state, nxt;
  logic [CW-1:0] cnt;
  logic expired;
  assign expired = cnt == '0;
  always_comb begin
    nxt = state;
    case (state)
      ST_LOCKED:   nxt = key_wr && key_data == KEY0 ? ST_KEY0_OK : ST_LOCKED;
      ST_KEY0_OK:  nxt = key_wr ? (key_data == KEY1 ? ST_UNLOCKED : ST_LOCKED) : expired ? ST_LOCKED : ST_KEY0_OK;
      ST_UNLOCKED: nxt = key_wr || prot_wr_done || expired ? ST_LOCKED : ST_UNLOCKED;
      default:     nxt = ST_LOCKED;
    endcase
  end
  // counter reloads on every state change so each state gets a full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOCKED;
      cnt      <= '0;
      unlocked <= 1'b0;
    end else begin
      state    <= nxt;
      unlocked <= nxt == ST_UNLOCKED;
      cnt      <= nxt != state ? (nxt == ST_LOCKED ? '0 : CW'(UNLOCK_WIN - 1)) : (expired ? cnt : cnt - 1'b1);
    end
  end
endmodule

// File: rtl/rw_reg_bank.sv
// rw_reg_bank: parametrised register bank with access types, mode permissions,
// per-register CRC store and key-protected registers
module rw_reg_bank
  import rw_reg_bank_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int CRC_W = 8,
  parameter int REG_NUM = 4,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter logic [REG_NUM*DW-1:0] DEFAULT_VAL = '0,
  parameter logic [REG_NUM*2-1:0] ACC_TYPE = '0,
  parameter logic [REG_NUM-1:0] PROT_MASK = '0,
  parameter logic [REG_NUM*4-1:0] WR_MODE_MASK = '1,
  parameter logic [REG_NUM*3-1:0] RD_MODE_MASK = '1,
  parameter logic [AW-1:0] UNLOCK_ADDR = 8'hFF,
  parameter logic [DW-1:0] KEY0 = 8'hA5,
  parameter logic [DW-1:0] KEY1 = 8'h5A,
  parameter int UNLOCK_WIN = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wen,
  input  logic                  i_ren,
  input  logic                  i_test_st_reg_en,
  input  logic                  i_cfg_st_reg_en,
  input  logic                  i_spi_ctrl_reg_en,
  input  logic                  i_efuse_ctrl_reg_en,
  input  logic [AW-1:0]         i_addr,
  input  logic [DW-1:0]         i_wdata,
  input  logic [CRC_W-1:0]      i_crc_data,
  input  logic [REG_NUM*DW-1:0] i_hw_set,
  input  logic [REG_NUM*DW-1:0] i_hw_val,
  output logic [DW-1:0]         o_rdata,
  output logic [CRC_W-1:0]      o_rcrc,
  output logic                  o_rvld,
  output logic [REG_NUM*DW-1:0] o_reg_data,
  output logic                  o_unlocked,
  output logic                  o_err
);
  localparam int IW = REG_NUM > 1 ? $clog2(REG_NUM) : 1;
  logic [REG_NUM*CRC_W-1:0] crc_all;
  logic [AW-1:0] off;
  logic [IW-1:0] idx;
  logic [3:0] en;
  acc_type_e acc;
  logic hit, ua, wr_only, rd_only, wr_try, rd_try, wr_mode_ok, rd_mode_ok;
  logic is_ro, prot, wr_acc, rd_acc, rd_ua, key_wr, err_n, unlocked;
  logic unused_ok;
  assign off        = i_addr - BASE_ADDR;
  assign hit        = off < AW'(REG_NUM);
  assign idx        = off[IW-1:0];
  assign ua         = i_addr == UNLOCK_ADDR;
  assign en[M_TEST]  = i_test_st_reg_en;
  assign en[M_CFG]   = i_cfg_st_reg_en;
  assign en[M_SPI]   = i_spi_ctrl_reg_en;
  assign en[M_EFUSE] = i_efuse_ctrl_reg_en;
  assign acc        = acc_type_e'(ACC_TYPE[idx*2 +: 2]);
  assign prot       = PROT_MASK[idx];
  assign wr_mode_ok = |(en & WR_MODE_MASK[idx*4 +: 4]);
  // read mask has no efuse bit, so it lines up with the low three enables
  assign rd_mode_ok = |(en[2:0] & RD_MODE_MASK[idx*3 +: 3]);
  assign is_ro      = acc == ACC_RO;
  assign wr_only    = i_wen & ~i_ren;
  assign rd_only    = i_ren & ~i_wen;
  assign wr_try     = wr_only & hit;
  assign rd_try     = rd_only & hit;
  assign wr_acc     = wr_try & wr_mode_ok & ~is_ro & (~prot | unlocked);
  assign rd_acc     = rd_try & rd_mode_ok;
  assign rd_ua      = rd_only & ua;
  assign key_wr     = wr_only & ua & |en;
  assign err_n      = (i_wen & i_ren) | ((i_wen | i_ren) & ~hit & ~ua) | (wr_try & ~wr_mode_ok)
                    | (rd_try & ~rd_mode_ok) | (wr_try & is_ro) | (wr_try & prot & ~unlocked)
                    | (wr_only & ua & ~|en);
  assign unused_ok  = ^{i_hw_set, i_hw_val};
  assign o_unlocked = unlocked;
  for (genvar k = 0; k < REG_NUM; k++) begin : g_reg
    localparam acc_type_e A = acc_type_e'(ACC_TYPE[k*2 +: 2]);
    logic [DW-1:0] q, set;
    logic [CRC_W-1:0] c;
    logic wsel, rsel;
    assign set  = i_hw_set[k*DW +: DW];
    assign wsel = wr_acc && idx == IW'(k);
    assign rsel = rd_acc && idx == IW'(k);
    assign o_reg_data[k*DW +: DW]  = q;
    assign crc_all[k*CRC_W +: CRC_W] = c;
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        q <= DEFAULT_VAL[k*DW +: DW];
        c <= '0;
      end else begin
        if (A == ACC_RO) q <= i_hw_val[k*DW +: DW];
        else if (wsel) q <= A == ACC_W1C ? (q & ~i_wdata) | set : i_wdata;
        else if (rsel && A == ACC_RC) q <= set;
        else if (A == ACC_W1C || A == ACC_RC) q <= q | set;
        if (wsel) c <= i_crc_data;
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rvld  <= 1'b0;
      o_rdata <= '0;
      o_rcrc  <= '0;
      o_err   <= 1'b0;
    end else begin
      o_rvld  <= rd_acc | rd_ua;
      o_rdata <= rd_acc ? o_reg_data[idx*DW +: DW] : rd_ua ? DW'(unlocked) : '0;
      o_rcrc  <= rd_acc ? crc_all[idx*CRC_W +: CRC_W] : '0;
      o_err   <= err_n;
    end
  end
  rw_reg_unlock_fsm #(
    .DW(DW), .KEY0(KEY0), .KEY1(KEY1), .UNLOCK_WIN(UNLOCK_WIN)
  ) u_fsm (
    .clk(i_clk),
    .rst(i_rst),
    .key_wr(key_wr),
    .key_data(i_wdata),
    .prot_wr_done(wr_acc & prot),
    .unlocked(unlocked)
  );
endmodule

// File: tb/tb_rw_reg_bank.sv
// tb_rw_reg_bank: directed self-checking bench for rw_reg_bank
module tb_rw_reg_bank;
  localparam int N = 6;
  localparam logic [N*8-1:0] DEF = {8'h00, 8'hAA, 8'h80, 8'hFF, 8'h00, 8'h12};
  logic i_clk = 0, i_rst = 1, i_wen = 0, i_ren = 0;
  logic i_test_st_reg_en = 0, i_cfg_st_reg_en = 0, i_spi_ctrl_reg_en = 1, i_efuse_ctrl_reg_en = 0;
  logic [7:0] i_addr = 0, i_wdata = 0, i_crc_data = 0;
  logic [N*8-1:0] i_hw_set = 0, i_hw_val = 0;
  logic [7:0] o_rdata, o_rcrc;
  logic o_rvld, o_unlocked, o_err;
  logic [N*8-1:0] o_reg_data;
  int checks = 0, failures = 0;
  rw_reg_bank #(
    .REG_NUM(N),
    .DEFAULT_VAL(DEF),
    .ACC_TYPE({2'd1, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0}),
    .PROT_MASK(6'b010000),
    .RD_MODE_MASK({3'b111, 3'b111, 3'b111, 3'b111, 3'b100, 3'b111})
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wen(i_wen), .i_ren(i_ren),
    .i_test_st_reg_en(i_test_st_reg_en), .i_cfg_st_reg_en(i_cfg_st_reg_en),
    .i_spi_ctrl_reg_en(i_spi_ctrl_reg_en), .i_efuse_ctrl_reg_en(i_efuse_ctrl_reg_en),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_crc_data(i_crc_data),
    .i_hw_set(i_hw_set), .i_hw_val(i_hw_val),
    .o_rdata(o_rdata), .o_rcrc(o_rcrc), .o_rvld(o_rvld), .o_reg_data(o_reg_data),
    .o_unlocked(o_unlocked), .o_err(o_err)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    i_addr = a; i_wdata = d; i_crc_data = c; i_wen = 1;
    tick();
    i_wen = 0;
  endtask
  task automatic rd(input logic [7:0] a);
    i_addr = a; i_ren = 1;
    tick();
    i_ren = 0;
  endtask
  initial begin
    tick();
    chk("rst_regs", o_reg_data, DEF);
    chk("rst_rvld", o_rvld, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_err", o_err, 0);
    chk("rst_unl", o_unlocked, 0);
    i_rst = 0;
    tick();
    rd(8'h00);
    chk("t1_rvld", o_rvld, 1);
    chk("t1_rdata", o_rdata, 8'h12);
    chk("t1_rcrc", o_rcrc, 0);
    tick();
    chk("t1_rvld_drop", o_rvld, 0);
    chk("t1_rdata_zero", o_rdata, 0);
    wr(8'h01, 8'h3C, 8'h91);
    chk("t2_reg1", o_reg_data[15:8], 8'h3C);
    chk("t2_err", o_err, 0);
    chk("t2_rvld_on_wr", o_rvld, 0);
    rd(8'h01);
    chk("t2_rdata", o_rdata, 8'h3C);
    chk("t2_rcrc", o_rcrc, 8'h91);
    chk("t2_rvld", o_rvld, 1);
    i_hw_set[23:16] = 8'h01;
    wr(8'h02, 8'h0F, 8'h00);
    i_hw_set = 0;
    chk("t3_w1c", o_reg_data[23:16], 8'hF1);
    tick();
    chk("t3_w1c_hold", o_reg_data[23:16], 8'hF1);
    rd(8'h03);
    chk("t4_rc_rdata", o_rdata, 8'h80);
    chk("t4_rc_clr", o_reg_data[31:24], 8'h00);
    rd(8'h03);
    chk("t4_rc_rdata2", o_rdata, 8'h00);
    chk("t4_rc_rvld2", o_rvld, 1);
    wr(8'h04, 8'h55, 8'h33);
    chk("t5_lock_err", o_err, 1);
    chk("t5_lock_reg", o_reg_data[39:32], 8'hAA);
    tick();
    chk("t5_err_pulse", o_err, 0);
    wr(8'hFF, 8'hA5, 8'h00);
    chk("t5_key0_unl", o_unlocked, 0);
    wr(8'hFF, 8'h5A, 8'h00);
    chk("t5_key1_unl", o_unlocked, 1);
    rd(8'hFF);
    chk("t5_ua_rdata", o_rdata, 8'h01);
    chk("t5_ua_rcrc", o_rcrc, 0);
    wr(8'h04, 8'h55, 8'h33);
    chk("t5_prot_reg", o_reg_data[39:32], 8'h55);
    chk("t5_prot_relock", o_unlocked, 0);
    chk("t5_prot_err", o_err, 0);
    rd(8'h04);
    chk("t5_prot_crc", o_rcrc, 8'h33);
    wr(8'hFF, 8'hA5, 8'h00);
    for (int i = 0; i < 17; i++) tick();
    wr(8'hFF, 8'h5A, 8'h00);
    chk("t5_timeout_unl", o_unlocked, 0);
    wr(8'h04, 8'h77, 8'h00);
    chk("t5_timeout_err", o_err, 1);
    chk("t5_timeout_reg", o_reg_data[39:32], 8'h55);
    i_addr = 8'h00; i_wdata = 8'h99; i_wen = 1; i_ren = 1;
    tick();
    i_wen = 0; i_ren = 0;
    chk("t6_both_err", o_err, 1);
    chk("t6_both_rvld", o_rvld, 0);
    chk("t6_both_reg", o_reg_data[7:0], 8'h12);
    wr(8'h10, 8'h77, 8'h00);
    chk("t6_oor_err", o_err, 1);
    chk("t6_oor_regs", o_reg_data, {8'h00, 8'h55, 8'h00, 8'hF1, 8'h3C, 8'h12});
    i_spi_ctrl_reg_en = 0; i_cfg_st_reg_en = 1;
    rd(8'h01);
    chk("t6_mask_err", o_err, 1);
    chk("t6_mask_rvld", o_rvld, 0);
    chk("t6_mask_rdata", o_rdata, 0);
    rd(8'h00);
    chk("t6_cfg_rd_ok", o_rdata, 8'h12);
    chk("t6_cfg_err", o_err, 0);
    i_spi_ctrl_reg_en = 1; i_cfg_st_reg_en = 0;
    i_hw_val[47:40] = 8'hC3;
    tick();
    chk("ro_track", o_reg_data[47:40], 8'hC3);
    wr(8'h05, 8'h11, 8'h00);
    chk("ro_wr_err", o_err, 1);
    chk("ro_wr_reg", o_reg_data[47:40], 8'hC3);
    wr(8'hFF, 8'hA5, 8'h00);
    i_rst = 1;
    #2;
    chk("midrst_regs", o_reg_data[39:0], DEF[39:0]);
    i_rst = 0;
    tick();
    wr(8'hFF, 8'h5A, 8'h00);
    chk("midrst_unl", o_unlocked, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
